// File: rtl/hm2_avalon_bus_bridge_if.sv
// Avalon-MM slave port plus strobe-style register bus seen by the HostMot2 bridge.
// The slave modport is the bridge side; the master modport is the HPS/decoder side.
interface hm2_avalon_bus_bridge_if #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32
);
  logic [AddrWidth-3:0] avs_address;
  logic                 avs_write;
  logic                 avs_read;
  logic [BusWidth-1:0]  avs_writedata;
  logic [BusWidth-1:0]  avs_readdata;
  logic                 avs_waitrequest;
  logic [BusWidth-1:0]  busdata_out;
  logic [AddrWidth-3:0] busaddress;
  logic [BusWidth-1:0]  busdata_in;
  logic                 write_reg;
  logic                 read_reg;

  modport slave (
    input  avs_address, avs_write, avs_read, avs_writedata, busdata_out,
    output avs_readdata, avs_waitrequest, busaddress, busdata_in, write_reg, read_reg
  );

  modport master (
    output avs_address, avs_write, avs_read, avs_writedata, busdata_out,
    input  avs_readdata, avs_waitrequest, busaddress, busdata_in, write_reg, read_reg
  );
endinterface

// File: rtl/hm2_avalon_bus_bridge.sv
// Avalon-MM to HostMot2 strobe-bus bridge with fixed read latency and write hold time.
// Define HM2_BRIDGE_POSTED_WRITE_EN to acknowledge writes in the accept cycle.
module hm2_avalon_bus_bridge #(
  parameter int AddrWidth   = 16,
  parameter int BusWidth    = 32,
  parameter int ReadLatency = 4,
  parameter int WriteHold   = 3
) (
  input logic                   reg_clk,
  input logic                   reset_reg,
  hm2_avalon_bus_bridge_if.slave bus
);

  if (ReadLatency < 1 || ReadLatency > 15) begin : g_bad_read_latency
    $error("hm2_avalon_bus_bridge: ReadLatency must be within 1..15");
  end
  if (WriteHold < 1 || WriteHold > 15) begin : g_bad_write_hold
    $error("hm2_avalon_bus_bridge: WriteHold must be within 1..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WSTROBE,
    ST_WHOLD,
    ST_RSTROBE,
    ST_RWAIT,
    ST_ACK
  } state_e;

  localparam logic [3:0] ReadLoad  = 4'(ReadLatency - 1);
  localparam logic [3:0] WriteLoad = 4'(WriteHold - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-3:0] busaddress_q, busaddress_d;
  logic [BusWidth-1:0]  busdata_in_q, busdata_in_d;
  logic [BusWidth-1:0]  avs_readdata_q, avs_readdata_d;
  logic                 write_reg_q, write_reg_d;
  logic                 read_reg_q, read_reg_d;
  logic                 req;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    busaddress_d   = busaddress_q;
    busdata_in_d   = busdata_in_q;
    avs_readdata_d = avs_readdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.avs_write) begin
          busaddress_d = bus.avs_address;
          busdata_in_d = bus.avs_writedata;
          state_d      = ST_WSTROBE;
        end else if (bus.avs_read) begin
          busaddress_d = bus.avs_address;
          state_d      = ST_RSTROBE;
        end
      end
      ST_WSTROBE: begin
        cnt_d   = WriteLoad;
        state_d = ST_WHOLD;
      end
      ST_WHOLD: begin
        if (cnt_q == 4'd0) begin
`ifdef HM2_BRIDGE_POSTED_WRITE_EN
          state_d = ST_IDLE;
`else
          state_d = ST_ACK;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RSTROBE: begin
        cnt_d   = ReadLoad;
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (cnt_q == 4'd0) begin
          avs_readdata_d = bus.busdata_out;
          state_d        = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they come straight out of flops.
    write_reg_d = (state_d == ST_WSTROBE);
    read_reg_d  = (state_d == ST_RSTROBE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      busaddress_q   <= '0;
      busdata_in_q   <= '0;
      avs_readdata_q <= '0;
      write_reg_q    <= 1'b0;
      read_reg_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      busaddress_q   <= busaddress_d;
      busdata_in_q   <= busdata_in_d;
      avs_readdata_q <= avs_readdata_d;
      write_reg_q    <= write_reg_d;
      read_reg_q     <= read_reg_d;
    end
  end

  assign req = bus.avs_read | bus.avs_write;

`ifdef HM2_BRIDGE_POSTED_WRITE_EN
  // A write presented in IDLE is taken immediately; the hold sequence runs behind it.
  assign bus.avs_waitrequest = reset_reg |
                               (req & (state_q != ST_ACK) &
                                ~((state_q == ST_IDLE) & bus.avs_write));
`else
  assign bus.avs_waitrequest = reset_reg | (req & (state_q != ST_ACK));
`endif

  assign bus.busaddress   = busaddress_q;
  assign bus.busdata_in   = busdata_in_q;
  assign bus.avs_readdata = avs_readdata_q;
  assign bus.write_reg    = write_reg_q;
  assign bus.read_reg     = read_reg_q;

endmodule

// File: tb/tb_hm2_avalon_bus_bridge.sv
// Randomized self-checking bench for hm2_avalon_bus_bridge against a transfer-level timing model.
// Honours HM2_BRIDGE_POSTED_WRITE_EN when the design is built with it.
module tb_hm2_avalon_bus_bridge;
  localparam int AW  = 16;
  localparam int BW  = 32;
  localparam int RL  = 4;
  localparam int WH  = 3;
  localparam int WIN = 24;
`ifdef HM2_BRIDGE_POSTED_WRITE_EN
  localparam bit Posted = 1'b1;
`else
  localparam bit Posted = 1'b0;
`endif
  localparam int ExpWrAck = Posted ? 0 : 2 + WH;
  localparam int ExpRdAck = 2 + RL;

  logic reg_clk;
  logic reset_reg;

  hm2_avalon_bus_bridge_if #(.AddrWidth(AW), .BusWidth(BW)) bus_if ();

  hm2_avalon_bus_bridge #(
    .AddrWidth  (AW),
    .BusWidth   (BW),
    .ReadLatency(RL),
    .WriteHold  (WH)
  ) u_dut (
    .reg_clk  (reg_clk),
    .reset_reg(reset_reg),
    .bus      (bus_if.slave)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  int n_vec = 0;
  int n_err = 0;

  // Architectural view of the bridge: what the bus should be showing between transfers.
  logic [AW-3:0] m_addr  = '0;
  logic [BW-1:0] m_wdata = '0;
  logic [BW-1:0] m_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One Avalon transfer observed over a fixed window. Cycle 0 is the cycle the request
  // is first presented; busdata_out shows rd_junk before cycle rd_sw and rd_val from it on.
  task automatic do_xfer(input bit is_wr, input logic [AW-3:0] addr, input logic [BW-1:0] data,
                         input logic [BW-1:0] rd_val, input logic [BW-1:0] rd_junk,
                         input int rd_sw);
    int ack_c = -1;
    int stb_c = -1;
    int n_stb = 0;
    int n_other = 0;
    bit req = 1'b1;
    bit addr_bad = 1'b0;
    bit wd_bad = 1'b0;
    bit rd_bad = 1'b0;
    bit idle_bad = 1'b0;
    logic [BW-1:0] rd_at_ack = '0;
    logic [BW-1:0] exp_rd;
    logic strobe, other;
    exp_rd = (1 + RL >= rd_sw) ? rd_val : rd_junk;
    for (int c = 0; c < WIN; c++) begin
      @(negedge reg_clk);
      if (c == 0) begin
        bus_if.avs_address   = addr;
        bus_if.avs_writedata = is_wr ? data : BW'($urandom);
        bus_if.avs_write     = is_wr;
        bus_if.avs_read      = !is_wr;
      end else if (req && ack_c >= 0) begin
        bus_if.avs_write = 1'b0;
        bus_if.avs_read  = 1'b0;
        req = 1'b0;
      end
      bus_if.busdata_out = (c >= rd_sw) ? rd_val : rd_junk;
      #1;
      if (req && ack_c < 0 && !bus_if.avs_waitrequest) begin
        ack_c = c;
        rd_at_ack = bus_if.avs_readdata;
      end
      if (!req && bus_if.avs_waitrequest) idle_bad = 1'b1;
      strobe = is_wr ? bus_if.write_reg : bus_if.read_reg;
      other  = is_wr ? bus_if.read_reg  : bus_if.write_reg;
      if (strobe) begin
        n_stb++;
        if (stb_c < 0) stb_c = c;
      end
      if (other) n_other++;
      if (c == 0 && bus_if.busaddress !== m_addr) addr_bad = 1'b1;
      if (c >= 1 && bus_if.busaddress !== addr) addr_bad = 1'b1;
      if (is_wr) begin
        if (c == 0 && bus_if.busdata_in !== m_wdata) wd_bad = 1'b1;
        if (c >= 1 && bus_if.busdata_in !== data) wd_bad = 1'b1;
        if (bus_if.avs_readdata !== m_rdata) rd_bad = 1'b1;
      end else begin
        if (bus_if.busdata_in !== m_wdata) wd_bad = 1'b1;
        if (c < ExpRdAck && bus_if.avs_readdata !== m_rdata) rd_bad = 1'b1;
        if (c >= ExpRdAck && bus_if.avs_readdata !== exp_rd) rd_bad = 1'b1;
      end
    end
    check(is_wr ? "wr_ack_cycle" : "rd_ack_cycle", 64'(ack_c), 64'(is_wr ? ExpWrAck : ExpRdAck));
    check("strobe_cycle", 64'(stb_c), 64'd1);
    check("strobe_count", 64'(n_stb), 64'd1);
    check("other_strobe", 64'(n_other), 64'd0);
    check("busaddress_stable", 64'(addr_bad), 64'd0);
    check("busdata_in_stable", 64'(wd_bad), 64'd0);
    check("readdata_hold", 64'(rd_bad), 64'd0);
    check("idle_waitrequest", 64'(idle_bad), 64'd0);
    if (!is_wr) check("readdata_at_ack", 64'(rd_at_ack), 64'(exp_rd));
    m_addr = addr;
    if (is_wr) m_wdata = data;
    else m_rdata = exp_rd;
  endtask

  initial begin
    int kind;
    int sw;
    logic [AW-3:0] a;
    logic [BW-1:0] d, v, j;

    // Reset with a read already asserted.
    reset_reg             = 1'b1;
    bus_if.avs_address    = 14'h0123;
    bus_if.avs_write      = 1'b0;
    bus_if.avs_read       = 1'b1;
    bus_if.avs_writedata  = '0;
    bus_if.busdata_out    = '0;
    repeat (3) @(negedge reg_clk);
    #1;
    check("rst_waitrequest", 64'(bus_if.avs_waitrequest), 64'd1);
    check("rst_write_reg", 64'(bus_if.write_reg), 64'd0);
    check("rst_read_reg", 64'(bus_if.read_reg), 64'd0);
    check("rst_busaddress", 64'(bus_if.busaddress), 64'd0);
    check("rst_busdata_in", 64'(bus_if.busdata_in), 64'd0);
    check("rst_readdata", 64'(bus_if.avs_readdata), 64'd0);
    @(negedge reg_clk);
    bus_if.avs_read = 1'b0;
    reset_reg = 1'b0;
    #1;
    check("post_rst_waitrequest", 64'(bus_if.avs_waitrequest), 64'd0);

    // Directed default write and read, read data changing at cycle 4.
    do_xfer(1'b1, 14'h0448, 32'hDEADBEEF, '0, '0, 0);
    do_xfer(1'b0, 14'h0448, '0, 32'h1234_5678, 32'h0, 4);
    // Data changing one cycle after the capture edge must not be seen.
    do_xfer(1'b0, 14'h0001, '0, 32'hCAFE_F00D, 32'h5555_AAAA, 2 + RL);

`ifndef HM2_BRIDGE_POSTED_WRITE_EN
    begin : simultaneous
      int wr_stb = -1, rd_stb = -1, wr_ack = -1, rd_ack = -1, overlap = 0;
      bit wr_on = 1'b1, rd_on = 1'b1;
      v = 32'h0BAD_BEEF;
      for (int c = 0; c < 2 * WIN; c++) begin
        @(negedge reg_clk);
        if (c == 0) begin
          bus_if.avs_address   = 14'h0200;
          bus_if.avs_writedata = 32'h1111_2222;
          bus_if.avs_write     = 1'b1;
          bus_if.avs_read      = 1'b1;
          bus_if.busdata_out   = v;
        end else begin
          if (wr_on && wr_ack >= 0) begin bus_if.avs_write = 1'b0; wr_on = 1'b0; end
          else if (rd_on && rd_ack >= 0) begin bus_if.avs_read = 1'b0; rd_on = 1'b0; end
        end
        #1;
        if (!bus_if.avs_waitrequest) begin
          if (wr_on && wr_ack < 0) wr_ack = c;
          else if (rd_on && !wr_on && rd_ack < 0) begin
            rd_ack = c;
            check("simul_readdata", 64'(bus_if.avs_readdata), 64'(v));
          end
        end
        if (bus_if.write_reg && wr_stb < 0) wr_stb = c;
        if (bus_if.read_reg && rd_stb < 0) rd_stb = c;
        if (bus_if.write_reg && bus_if.read_reg) overlap++;
      end
      check("simul_wr_strobe", 64'(wr_stb), 64'd1);
      check("simul_wr_ack", 64'(wr_ack), 64'(2 + WH));
      check("simul_rd_strobe", 64'(rd_stb), 64'(4 + WH));
      check("simul_rd_ack", 64'(rd_ack), 64'(5 + WH + RL));
      check("simul_overlap", 64'(overlap), 64'd0);
      m_addr = 14'h0200;
      m_wdata = 32'h1111_2222;
      m_rdata = v;
    end
`else
    begin : posted
      int wr_ack = -1, wr_stb = -1, rd_stb = -1, rd_ack = -1;
      v = 32'h7777_8888;
      for (int c = 0; c < WIN; c++) begin
        @(negedge reg_clk);
        if (c == 0) begin
          bus_if.avs_address   = 14'h0300;
          bus_if.avs_writedata = 32'hA5A5A5A5;
          bus_if.avs_write     = 1'b1;
          bus_if.busdata_out   = v;
        end else if (c == 1) begin
          bus_if.avs_write = 1'b0;
          bus_if.avs_read  = 1'b1;
        end else if (rd_ack >= 0) begin
          bus_if.avs_read = 1'b0;
        end
        #1;
        if (c == 0 && !bus_if.avs_waitrequest) wr_ack = 0;
        if (c >= 1 && bus_if.avs_read && !bus_if.avs_waitrequest && rd_ack < 0) begin
          rd_ack = c;
          check("posted_readdata", 64'(bus_if.avs_readdata), 64'(v));
        end
        if (bus_if.write_reg && wr_stb < 0) wr_stb = c;
        if (bus_if.read_reg && rd_stb < 0) rd_stb = c;
        if (c == 2) check("posted_busdata_in", 64'(bus_if.busdata_in), 64'hA5A5A5A5);
      end
      check("posted_wr_ack", 64'(wr_ack), 64'd0);
      check("posted_wr_strobe", 64'(wr_stb), 64'd1);
      check("posted_rd_strobe", 64'(rd_stb), 64'(3 + WH));
      check("posted_rd_ack", 64'(rd_ack), 64'(4 + WH + RL));
      m_addr = 14'h0300;
      m_wdata = 32'hA5A5A5A5;
      m_rdata = v;
    end
`endif

    // Random mix of reads and writes with random idle gaps.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 1));
      a = AW'($urandom) & 14'h3FFF;
      d = BW'($urandom);
      v = BW'($urandom);
      j = BW'($urandom);
      sw = int'($urandom_range(0, 2 + RL));
      do_xfer(kind == 1, a, d, v, j, sw);
      repeat ($urandom_range(0, 3)) @(negedge reg_clk);
    end

    // Reset pulsed while the read is waiting on the decoder.
    @(negedge reg_clk);
    bus_if.avs_address = 14'h0ABC;
    bus_if.avs_read    = 1'b1;
    bus_if.busdata_out = 32'hFEED_FACE;
    repeat (3) @(negedge reg_clk);
    #2;
    reset_reg = 1'b1;
    bus_if.avs_read = 1'b0;
    #1;
    check("midrst_read_reg", 64'(bus_if.read_reg), 64'd0);
    check("midrst_waitrequest", 64'(bus_if.avs_waitrequest), 64'd1);
    check("midrst_readdata", 64'(bus_if.avs_readdata), 64'd0);
    check("midrst_busaddress", 64'(bus_if.busaddress), 64'd0);
    @(negedge reg_clk);
    reset_reg = 1'b0;
    begin : after_reset
      int strobes = 0;
      int rd_nonzero = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge reg_clk);
        #1;
        if (bus_if.read_reg || bus_if.write_reg) strobes++;
        if (bus_if.avs_readdata !== '0) rd_nonzero++;
      end
      check("midrst_no_strobe", 64'(strobes), 64'd0);
      check("midrst_readdata_zero", 64'(rd_nonzero), 64'd0);
    end
    m_addr = '0;
    m_wdata = '0;
    m_rdata = '0;
    do_xfer(1'b0, 14'h0ABC, '0, 32'h600D_0001, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
